uart_rx_monitor: RTL and testbench

- Parametrised serial receive monitor on the CPU's `uart_tx` line; next generation of the CPU bench harness.
- Decodes UART frames of configurable width and parity, and buffers characters in a FIFO.
- Flags framing, parity and overflow errors.
- Replaces the fixed-delay end of simulation with `done` (end-of-test character received) and `timeout` (line silent too long), so benches finish on events.

---
 rtl/uart_rx_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: 2-flop synchroniser, frame decoder, FWFT FIFO, done/timeout flags.
// Build option UART_MON_DISPLAY_EN echoes received characters and error reports to the simulator console.
`timescale 1ns/1ps
module uart_rx_monitor #(
  parameter int          CLKS_PER_BIT   = 87,
  parameter int          DATA_BITS      = 8,
  parameter int          PARITY_MODE    = 0,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [7:0]  END_CHAR       = 8'h04,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                            sysclk,
  input  logic                            cpu_resetn,
  input  logic                            uart_rx,
  input  logic                            rd_en,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overflow,
  output logic                            done,
  output logic                            timeout
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CMP_W = (DATA_BITS < 8) ? DATA_BITS : 8;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // synchroniser
  logic rx_meta, rx_sync;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // frame decoder
  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 push_pend, push_n;
  logic                 ferr_n, perr_n;
  logic                 start_det;
  logic                 par_exp;

  assign par_exp = (PARITY_MODE == 1) ? ~(^shreg) : (^shreg);

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      push_pend  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      push_pend  <= push_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    push_n    = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    start_det = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          state_n   = S_START;
          cnt_n     = CNT_HALF;
          start_det = 1'b1;
        end
      end
      S_START: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (!rx_sync) begin
          state_n   = S_DATA;
          cnt_n     = CNT_MAX;
          bit_n     = '0;
          par_bad_n = 1'b0;
        end else state_n = S_IDLE;
      end
      S_DATA: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          shreg_n = {rx_sync, shreg[DATA_BITS-1:1]};
          cnt_n   = CNT_MAX;
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          par_bad_n = (rx_sync != par_exp);
          cnt_n     = CNT_MAX;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (rx_sync) begin
          state_n = S_IDLE;
          if (par_bad) perr_n = 1'b1;
          else         push_n = 1'b1;
        end else begin
          ferr_n  = 1'b1;
          state_n = S_BREAK;
        end
      end
      S_BREAK: begin
        // a held-low line must return high before a new start can be seen
        if (rx_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // idle / timeout counter
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn)                                   idle_cnt <= '0;
    else if (start_det)                                idle_cnt <= '0;
    else if (state == S_IDLE && idle_cnt != TO_MAX)    idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idle_cnt == TO_MAX);

  // receive FIFO, first-word fall-through
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, pop, do_push, ovf_set, end_hit;

  assign full    = (count == FULL_CNT);
  assign pop     = rd_en && (count != '0);
  assign do_push = push_pend && (!full || pop);
  assign ovf_set = push_pend && full && !pop;
  // a dropped END_CHAR still ends the test
  assign end_hit = push_pend && (shreg[CMP_W-1:0] == END_CHAR[CMP_W-1:0]);

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) overflow <= 1'b1;
      if (end_hit) done     <= 1'b1;
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

`ifdef UART_MON_DISPLAY_EN
  always_ff @(posedge sysclk) begin
    if (cpu_resetn) begin
      if (do_push)          $write("%c", shreg);
      if (frame_err)        $display("%0t uart_rx_monitor: framing error", $time);
      if (parity_err)       $display("%0t uart_rx_monitor: parity error", $time);
      if (end_hit && !done) $display("UART END");
    end
  end
`else
  // console echo is left out of this build; port behaviour is the same
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: 8N1 instance (depth 4, short timeout) and 8E1 instance.
`timescale 1ns/1ps
module tb_uart_rx_monitor;
  localparam int CPB = 87;

  logic       sysclk = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic       line_a = 1'b1, line_b = 1'b1;
  logic       rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic       frame_err_a, frame_err_b, parity_err_a, parity_err_b;
  logic       overflow_a, overflow_b, done_a, done_b, timeout_a, timeout_b;

  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_a[$], exp_b[$];
  int req_a = 0, req_b = 0, srv_a = 0, srv_b = 0;
  int ferr_a = 0, perr_a = 0, ferr_b = 0, perr_b = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4),
                    .END_CHAR(8'h04), .TIMEOUT_CYCLES(1000)) u_a (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .uart_rx(line_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_count(cnt_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overflow(overflow_a),
    .done(done_a), .timeout(timeout_a));

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(16)) u_b (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .uart_rx(line_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .fifo_count(cnt_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overflow(overflow_b),
    .done(done_b), .timeout(timeout_b));

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One frame on line w (0 = a, 1 = b). store: character is expected in the FIFO.
  // pop_at: negedge index within the frame at which one read is requested (-1 = none).
  task automatic frame(input bit w, input logic [7:0] d, input bit use_par, input bit par,
                       input bit stp, input bit store, input int pop_at);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (use_par) begin bits[9] = par; bits[10] = stp; nb = 11; end
    else begin bits[9] = stp; nb = 10; end
    if (store) begin
      if (w) exp_b.push_back(d);
      else   exp_a.push_back(d);
    end
    for (int i = 0; i < nb * CPB; i++) begin
      @(negedge sysclk);
      if (i % CPB == 0) begin
        if (w) line_b = bits[i / CPB];
        else   line_a = bits[i / CPB];
      end
      if (i == pop_at) begin
        #2;
        if (w) req_b++;
        else   req_a++;
      end
    end
  endtask

  initial begin
    fork
      // monitor: counts error pulses, serves read requests and checks popped data
      forever begin
        @(negedge sysclk);
        ferr_a += int'(frame_err_a);
        perr_a += int'(parity_err_a);
        ferr_b += int'(frame_err_b);
        perr_b += int'(parity_err_b);
        if (rd_valid_a && req_a > srv_a) begin
          if (exp_a.size() == 0) chk("a_sb_nonempty", exp_a.size(), 1);
          else                   chk("a_data", rd_data_a, exp_a.pop_front());
          rd_en_a = 1'b1;
          srv_a++;
        end else rd_en_a = 1'b0;
        if (rd_valid_b && req_b > srv_b) begin
          if (exp_b.size() == 0) chk("b_sb_nonempty", exp_b.size(), 1);
          else                   chk("b_data", rd_data_b, exp_b.pop_front());
          rd_en_b = 1'b1;
          srv_b++;
        end else rd_en_b = 1'b0;
      end

      // stimulus
      begin
        idle(3);
        chk("rst_count_a", cnt_a, 0);
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_ovf_a", overflow_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_timeout_a", timeout_a, 0);
        chk("rst_ferr_a", frame_err_a, 0);
        chk("rst_count_b", cnt_b, 0);
        cpu_resetn = 1'b1;

        // idle timeout
        idle(995);
        chk("timeout_early", timeout_a, 0);
        idle(10);
        chk("timeout_set", timeout_a, 1);
        chk("timeout_b_long", timeout_b, 0);

        // two good 8N1 characters
        frame(0, 8'h41, 0, 0, 1, 1, -1);
        chk("timeout_drop", timeout_a, 0);
        frame(0, 8'h42, 0, 0, 1, 1, -1);
        idle(20);
        chk("two_count", cnt_a, 2);
        chk("two_valid", rd_valid_a, 1);
        chk("two_no_err", ferr_a + perr_a, 0);
        chk("two_no_ovf", overflow_a, 0);
        req_a += 2;
        idle(10);
        chk("two_drained", cnt_a, 0);
        chk("two_served", srv_a, req_a);

        // framing error, line held low, then a good character
        frame(0, 8'h55, 0, 0, 0, 0, -1);
        idle(300);
        line_a = 1'b1;
        idle(2 * CPB);
        frame(0, 8'h33, 0, 0, 1, 1, -1);
        idle(20);
        chk("ferr_pulses", ferr_a, 1);
        chk("ferr_count", cnt_a, 1);
        req_a++;
        idle(5);
        chk("ferr_drained", cnt_a, 0);

        // 40-cycle glitch is rejected
        @(negedge sysclk);
        line_a = 1'b0;
        idle(40);
        line_a = 1'b1;
        idle(200);
        chk("glitch_count", cnt_a, 0);
        chk("glitch_ferr", ferr_a, 1);
        chk("glitch_perr", perr_a, 0);

        // fill, push+pop while full, then overflow
        for (int k = 0; k < 4; k++) frame(0, 8'(8'h61 + k), 0, 0, 1, 1, -1);
        idle(5);
        chk("full_count", cnt_a, 4);
        chk("full_no_ovf", overflow_a, 0);
        frame(0, 8'h65, 0, 0, 1, 1, 828);
        idle(5);
        chk("pushpop_count", cnt_a, 4);
        chk("pushpop_no_ovf", overflow_a, 0);
        chk("pushpop_served", srv_a, req_a);
        frame(0, 8'h66, 0, 0, 1, 0, -1);
        idle(5);
        chk("ovf_count", cnt_a, 4);
        chk("ovf_set", overflow_a, 1);
        chk("ovf_no_done", done_a, 0);
        req_a += 4;
        idle(10);
        chk("ovf_drained", cnt_a, 0);
        chk("ovf_served", srv_a, req_a);

        // end-of-test character
        frame(0, 8'h04, 0, 0, 1, 1, -1);
        idle(5);
        chk("done_set", done_a, 1);
        chk("done_count", cnt_a, 1);
        chk("done_timeout", timeout_a, 0);

        // reset clears FIFO and sticky flags
        cpu_resetn = 1'b0;
        idle(1);
        chk("rst2_count", cnt_a, 0);
        chk("rst2_done", done_a, 0);
        chk("rst2_ovf", overflow_a, 0);
        exp_a.delete();
        idle(2);
        cpu_resetn = 1'b1;
        idle(5);

        // even parity on b: 0x07 needs parity bit 1
        frame(1, 8'h07, 1, 0, 1, 0, -1);
        idle(5);
        chk("par_bad_pulse", perr_b, 1);
        chk("par_bad_count", cnt_b, 0);
        frame(1, 8'h07, 1, 1, 1, 1, -1);
        idle(5);
        chk("par_good_count", cnt_b, 1);
        frame(1, 8'hA5, 1, 0, 1, 1, -1);
        idle(5);
        chk("par_good2_count", cnt_b, 2);
        chk("par_pulses", perr_b, 1);
        chk("par_no_ferr", ferr_b, 0);
        req_b += 2;
        idle(10);
        chk("par_drained", cnt_b, 0);
        chk("par_served", srv_b, req_b);
        chk("sb_a_empty", exp_a.size(), 0);
        chk("sb_b_empty", exp_b.size(), 0);
      end

      begin
        #2000000;
        n_chk++;
        $display("FAIL watchdog: stimulus did not complete in time");
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
